// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with valid/ready output.
// Optional skid entry gives a fully registered upstream ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [24:0]      i_inst,
  input  logic [2:0]       i_imm_sel,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [TAG_W-1:0] o_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // i_inst[k] holds instruction bit k+7
  logic [XLEN-1:0] imm_d;

  always_comb begin
    imm_d = '0;
    unique case (i_imm_sel)
      3'b000: imm_d = XLEN'($signed(i_inst[24:13]));
      3'b001: imm_d = XLEN'(i_inst[24:13]);
      3'b010: imm_d = XLEN'($signed({i_inst[24:18],
                                     i_inst[4:0]}));
      3'b011: imm_d = XLEN'($signed({i_inst[24], i_inst[0],
                                     i_inst[23:18],
                                     i_inst[4:1], 1'b0}));
      3'b100: imm_d = XLEN'($signed({i_inst[24:5], 12'b0}));
      3'b101: imm_d = XLEN'($signed({i_inst[24],
                                     i_inst[12:5],
                                     i_inst[13],
                                     i_inst[23:14], 1'b0}));
      3'b110: imm_d = XLEN'(i_inst[12:8]);
      3'b111: imm_d = (XLEN == 64) ? XLEN'(i_inst[18:13])
                                   : XLEN'(i_inst[17:13]);
      default: imm_d = '0;
    endcase
  end

  if (SKID == 0) begin : g_single
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  imm_q, imm_nx;
    logic [TAG_W-1:0] tag_q, tag_nx;
    logic             rdy, in_xfer, out_xfer;

    assign rdy      = !valid_q || i_ready;
    assign in_xfer  = i_valid && rdy;
    assign out_xfer = valid_q && i_ready;

    always_comb begin
      valid_d = valid_q;
      imm_nx  = imm_q;
      tag_nx  = tag_q;
      if (in_xfer) begin
        valid_d = 1'b1;
        imm_nx  = imm_d;
        tag_nx  = i_tag;
      end else if (out_xfer) begin
        valid_d = 1'b0;
      end
      if (i_flush) begin
        valid_d = 1'b0;
        imm_nx  = imm_q;
        tag_nx  = tag_q;
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        valid_q <= 1'b0;
        imm_q   <= '0;
        tag_q   <= '0;
      end else begin
        valid_q <= valid_d;
        imm_q   <= imm_nx;
        tag_q   <= tag_nx;
      end
    end

    assign o_ready = rdy;
    assign o_valid = valid_q;
    assign o_imm   = imm_q;
    assign o_tag   = tag_q;
  end else begin : g_skid
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [XLEN-1:0]  sk_imm_q, sk_imm_d;
    logic [TAG_W-1:0] sk_tag_q, sk_tag_d;
    logic             vld, in_xfer, out_xfer;

    assign vld      = (state_q != EMPTY);
    assign in_xfer  = i_valid && rdy_q;
    assign out_xfer = vld && i_ready;

    always_comb begin
      state_d   = state_q;
      out_imm_d = out_imm_q;
      out_tag_d = out_tag_q;
      sk_imm_d  = sk_imm_q;
      sk_tag_d  = sk_tag_q;
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d   = ONE;
            out_imm_d = imm_d;
            out_tag_d = i_tag;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_imm_d = imm_d;
            out_tag_d = i_tag;
          end else if (in_xfer) begin
            state_d  = TWO;
            sk_imm_d = imm_d;
            sk_tag_d = i_tag;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d   = ONE;
            out_imm_d = sk_imm_q;
            out_tag_d = sk_tag_q;
          end
        end
        default: state_d = EMPTY;
      endcase
      // flush drops entries but leaves stale payload in place
      if (i_flush) begin
        state_d   = EMPTY;
        out_imm_d = out_imm_q;
        out_tag_d = out_tag_q;
        sk_imm_d  = sk_imm_q;
        sk_tag_d  = sk_tag_q;
      end
      rdy_d = (state_d != TWO);
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        state_q   <= EMPTY;
        rdy_q     <= 1'b1;
        out_imm_q <= '0;
        out_tag_q <= '0;
        sk_imm_q  <= '0;
        sk_tag_q  <= '0;
      end else begin
        state_q   <= state_d;
        rdy_q     <= rdy_d;
        out_imm_q <= out_imm_d;
        out_tag_q <= out_tag_d;
        sk_imm_q  <= sk_imm_d;
        sk_tag_q  <= sk_tag_d;
      end
    end

    assign o_ready = rdy_q;
    assign o_valid = vld;
    assign o_imm   = out_imm_q;
    assign o_tag   = out_tag_q;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: XLEN=32 skid instance and XLEN=64 single-register
// instance share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, vld, rdy;
  logic [24:0] inst;
  logic [2:0]  sel;
  logic [4:0]  tag;

  logic        a_ready, a_valid;
  logic [31:0] a_imm;
  logic [4:0]  a_tag;
  logic        b_ready, b_valid;
  logic [63:0] b_imm;
  logic [4:0]  b_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID(1), .TAG_W(5)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_valid(vld), .o_ready(a_ready), .i_inst(inst),
    .i_imm_sel(sel), .i_tag(tag), .o_valid(a_valid),
    .i_ready(rdy), .o_imm(a_imm), .o_tag(a_tag)
  );

  imm_gen_pipe #(.XLEN(64), .SKID(0), .TAG_W(5)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_valid(vld), .o_ready(b_ready), .i_inst(inst),
    .i_imm_sel(sel), .i_tag(tag), .o_valid(b_valid),
    .i_ready(rdy), .o_imm(b_imm), .o_tag(b_tag)
  );

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] s, input logic [31:0] w,
                     input logic [4:0] t);
    logic [31:0] v;
    v    = w;
    sel  = s;
    inst = v[31:7];
    tag  = t;
  endtask

  // both instances must present the same request, one cycle later
  task automatic imm_case(input string nm, input logic [2:0] s,
                          input logic [31:0] w, input logic [4:0] t,
                          input logic [31:0] e32,
                          input logic [63:0] e64);
    put(s, w, t);
    vld = 1'b1;
    step();
    chk({nm, "_v32"}, 64'(a_valid), 64'd1);
    chk({nm, "_i32"}, 64'(a_imm), 64'(e32));
    chk({nm, "_t32"}, 64'(a_tag), 64'(t));
    chk({nm, "_r32"}, 64'(a_ready), 64'd1);
    chk({nm, "_v64"}, 64'(b_valid), 64'd1);
    chk({nm, "_i64"}, b_imm, e64);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; vld = 1'b0; rdy = 1'b1;
    inst = '0; sel = '0; tag = '0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_v32", 64'(a_valid), 64'd0);
    chk("rst_i32", 64'(a_imm), 64'd0);
    chk("rst_t32", 64'(a_tag), 64'd0);
    chk("rst_r32", 64'(a_ready), 64'd1);
    chk("rst_v64", 64'(b_valid), 64'd0);
    chk("rst_r64", 64'(b_ready), 64'd1);

    imm_case("i", 3'b000, 32'hFFF00093, 5'd1,
             32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    imm_case("b", 3'b011, 32'hFE000EE3, 5'd2,
             32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    imm_case("u", 3'b100, 32'h800000B7, 5'd3,
             32'h80000000, 64'hFFFFFFFF80000000);
    imm_case("z", 3'b110, 32'h800F8073, 5'd4,
             32'h0000001F, 64'h000000000000001F);
    imm_case("sh", 3'b111, 32'h03F00013, 5'd5,
             32'h0000001F, 64'h000000000000003F);
    imm_case("iu", 3'b001, 32'hFFF00013, 5'd6,
             32'h00000FFF, 64'h0000000000000FFF);
    imm_case("s", 3'b010, 32'hFE112E23, 5'd7,
             32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    imm_case("j", 3'b101, 32'hFFDFF06F, 5'd8,
             32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    imm_case("ipos", 3'b000, 32'h7FF00093, 5'd9,
             32'h000007FF, 64'h00000000000007FF);
    vld = 1'b0;
    step();
    chk("drain_v32", 64'(a_valid), 64'd0);
    chk("drain_v64", 64'(b_valid), 64'd0);

    // stall with skid: tags 1..4, imm equals tag
    rdy = 1'b0; vld = 1'b1;
    put(3'b000, 32'h00100013, 5'd1);
    step();
    chk("st1_v", 64'(a_valid), 64'd1);
    chk("st1_t", 64'(a_tag), 64'd1);
    chk("st1_r", 64'(a_ready), 64'd1);
    put(3'b000, 32'h00200013, 5'd2);
    step();
    chk("st2_t", 64'(a_tag), 64'd1);
    chk("st2_i", 64'(a_imm), 64'd1);
    chk("st2_r", 64'(a_ready), 64'd0);
    put(3'b000, 32'h00300013, 5'd3);
    step();
    chk("st3_t", 64'(a_tag), 64'd1);
    chk("st3_r", 64'(a_ready), 64'd0);
    rdy = 1'b1;
    step();
    chk("dq2_t", 64'(a_tag), 64'd2);
    chk("dq2_i", 64'(a_imm), 64'd2);
    chk("dq2_r", 64'(a_ready), 64'd1);
    step();
    chk("dq3_t", 64'(a_tag), 64'd3);
    chk("dq3_i", 64'(a_imm), 64'd3);
    put(3'b000, 32'h00400013, 5'd4);
    step();
    chk("dq4_t", 64'(a_tag), 64'd4);
    chk("dq4_v", 64'(a_valid), 64'd1);
    vld = 1'b0;
    step();
    chk("dq_end_v", 64'(a_valid), 64'd0);

    // flush while two entries are held
    rdy = 1'b0; vld = 1'b1;
    put(3'b000, 32'h00500013, 5'd5);
    step();
    put(3'b000, 32'h00600013, 5'd6);
    step();
    chk("fl_full_r", 64'(a_ready), 64'd0);
    flush = 1'b1;
    put(3'b000, 32'h00700013, 5'd7);
    step();
    flush = 1'b0; vld = 1'b0;
    chk("fl_v32", 64'(a_valid), 64'd0);
    chk("fl_r32", 64'(a_ready), 64'd1);
    chk("fl_v64", 64'(b_valid), 64'd0);
    rdy = 1'b1;
    step();
    chk("fl_gone", 64'(a_valid), 64'd0);

    // reset in the middle of a stall
    rdy = 1'b0; vld = 1'b1;
    put(3'b000, 32'h00900013, 5'd9);
    step();
    chk("rs_pre_v", 64'(a_valid), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; vld = 1'b0;
    chk("rs_v32", 64'(a_valid), 64'd0);
    chk("rs_i32", 64'(a_imm), 64'd0);
    chk("rs_t32", 64'(a_tag), 64'd0);
    chk("rs_v64", 64'(b_valid), 64'd0);
    chk("rs_i64", b_imm, 64'd0);
    chk("rs_t64", 64'(b_tag), 64'd0);
    chk("rs_r32", 64'(a_ready), 64'd1);

    // back-to-back, one transfer per cycle
    rdy = 1'b1; vld = 1'b1;
    for (int k = 10; k < 14; k++) begin
      put(3'b000, 32'(k) << 20, 5'(k));
      step();
      chk("b2b_t32", 64'(a_tag), 64'(k));
      chk("b2b_i32", 64'(a_imm), 64'(k));
      chk("b2b_r32", 64'(a_ready), 64'd1);
      chk("b2b_t64", 64'(b_tag), 64'(k));
    end
    vld = 1'b0;
    step();
    chk("b2b_end", 64'(a_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage. It takes instruction bits [31:7] and an immediate-type select, builds the sign- or zero-extended immediate at XLEN width, and presents it downstream through a valid/ready interface. Compared with the combinational generator, it adds XLEN generalisation, CSR-zimm and shift-amount modes, a sideband tag, flush, and an optional skid buffer that gives a registered o_ready.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64
SKID, 1, 0 = single output register with combinational o_ready; 1 = output register plus one-entry skid buffer with registered o_ready
TAG_W, 5, width of the sideband tag carried with each immediate (e.g. rd index or ROB id)

Ports:
i_clk  input  1  clock; all logic is on the rising edge
i_rst_n  input  1  synchronous, active-low reset
i_flush  input  1  synchronous pipeline flush; discards all held entries
i_valid  input  1  upstream request valid
o_ready  output  1  block can accept a request this cycle
i_inst  input  25  instruction bits [31:7]
i_imm_sel  input  3  immediate type select
i_tag  input  TAG_W  sideband tag, passed through unchanged
o_valid  output  1  o_imm and o_tag are valid
i_ready  input  1  downstream accepts the output
o_imm  output  XLEN  generated immediate
o_tag  output  TAG_W  tag associated with o_imm

Behaviour:
- Immediate select encoding (s = sign-extend from the instruction's bit 31 to XLEN; z = zero-extend):
  - 000 I: s, bits {inst[31:20]}
  - 001 I-unsigned: z, bits inst[31:20]
  - 010 S: s, bits {inst[31:25], inst[11:7]}
  - 011 B: s, bits {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - 100 U: {inst[31:12], 12'b0}; when XLEN=64, sign-extend from bit 31
  - 101 J: s, bits {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - 110 CSR zimm: z, bits inst[19:15]
  - 111 shamt: z, bits inst[25:20] when XLEN=64; inst[24:20] when XLEN=32
- Generation is combinational from the input; the result is captured together with i_tag on the accept edge.
- Handshake rules:
  - An input transfer occurs when i_valid && o_ready.
  - An output transfer occurs when o_valid && i_ready.
  - Latency is 1 cycle: a request accepted at edge N is visible on o_imm with o_valid=1 after edge N.
  - While o_valid=1 && i_ready=0, o_imm and o_tag must remain stable.
  - The block never drops an accepted request and never duplicates one.
  - Throughput is one transfer per cycle when downstream is ready.
- SKID=0:
  - o_ready = !o_valid || i_ready (combinational).
  - The output register loads on every input transfer.
- SKID=1, state machine with states EMPTY, ONE (output register full) and TWO (output and skid full); o_ready = (state != TWO), driven from a register:
  - EMPTY: input transfer -> ONE.
  - ONE: input transfer with no output transfer -> TWO, and the new entry goes to the skid buffer.
  - ONE: output transfer with no input transfer -> EMPTY.
  - ONE: input and output transfer together -> stay in ONE; the output register reloads with the new entry.
  - TWO: output transfer -> ONE; the skid entry moves to the output register.
  - TWO: no input is accepted (o_ready=0).
  - Ordering is strictly FIFO.
- Reset (i_rst_n=0 at an edge):
  - o_valid=0, o_imm=0, o_tag=0, skid buffer empty, state EMPTY, o_ready=1 from the next cycle onward.
  - Reset overrides flush and any handshake in the same cycle.
  - Reset mid-stall discards all entries.
- Flush (i_flush=1 at an edge):
  - Same clearing effect as reset on valid/state; o_imm and o_tag may keep stale data.
  - An input offered in the flush cycle is not captured.
  - o_ready=1 in the following cycle.
- Width rules:
  - All extension is performed to exactly XLEN bits.
  - XLEN values other than 32 or 64 are illegal (elaboration-time assertion).

Test Plan:
- XLEN=32, sel=000, inst=0xFFF00093 -> one cycle later o_valid=1, o_imm=0xFFFFFFFF; with XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
- sel=011, inst=0xFE000EE3 (beq -4) -> o_imm=0xFFFFFFFC (XLEN=32); sel=100, inst=0x800000B7 -> 0x80000000 (XLEN=32) and 0xFFFFFFFF80000000 (XLEN=64).
- sel=110, inst bits [19:15]=0x1F -> o_imm=0x1F; sel=111 with inst[25:20]=0x3F -> 0x3F (XLEN=64), 0x1F (XLEN=32); sel=001, inst=0xFFF00013 -> 0x00000FFF.
- SKID=1, stream of 4 requests with tags 1-4 and i_ready held low for 3 cycles -> o_ready falls after 2 accepts, o_imm/o_tag stay at tag 1, then tags 1, 2, 3, 4 emerge in order with none lost or duplicated.
- SKID=1 in state TWO, assert i_flush for 1 cycle with i_valid=1 -> next cycle o_valid=0, o_ready=1, and the flush-cycle input does not appear.
- Assert i_rst_n=0 mid-stall with o_valid=1 -> after the edge o_valid=0, o_imm=0, o_tag=0; back-to-back requests with i_ready=1 then sustain 1 transfer per cycle.
